// File: rtl/gshare_pkg.sv
// rtl/gshare_pkg.sv - shared types and helpers for the gshare/BTB predictor
//
// Purpose : 2-bit counter type, BTB entry layout, FSM state encoding,
//           saturating counter update and the fall-through stride.
// Ports   : none (package).
package gshare_pkg;

  typedef logic [1:0] ctr2_t;

  // Tag field is sized for the smallest legal index (tag up to 30 bits).
  // Narrower tags are stored zero-extended, so the top bits stay constant.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
  } btb_entry_t;

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [31:0] FALLTHRU = 32'd4;

  function automatic ctr2_t sat_inc_dec(ctr2_t c, bit up);
    if (up) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// rtl/gshare_pht.sv - pattern history table of 2-bit saturating counters
//
// Purpose : counter array with one combinational read port, one
//           read-modify-write update port and a clear port.
// Ports   : clk                       clock
//           rd_idx / rd_ctr           lookup index / counter value
//           upd_en, upd_idx, upd_up   saturating +1 (up=1) or -1 (up=0)
//           clr_en, clr_idx           write INIT_VAL at clr_idx
module gshare_pht
  import gshare_pkg::*;
#(
  parameter int          IDX_BITS = 7,
  parameter logic [1:0]  INIT_VAL = 2'b01
) (
  input  logic                clk,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [1:0]          rd_ctr,
  input  logic                upd_en,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_up,
  input  logic                clr_en,
  input  logic [IDX_BITS-1:0] clr_idx
);

  ctr2_t mem [1 << IDX_BITS];

  assign rd_ctr = mem[rd_idx];

  // No reset on storage: the owner sweeps clr_idx after every reset.
  // Clear and update are never active together (update needs RUN).
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_idx] <= INIT_VAL;
    end else if (upd_en) begin
      mem[upd_idx] <= sat_inc_dec(mem[upd_idx], upd_up);
    end
  end

endmodule

// File: rtl/gshare_btb_predictor.sv
// rtl/gshare_btb_predictor.sv - gshare direction predictor with direct-mapped BTB
//
// Purpose : fetch-stage branch predictor. A PC presented with pred_valid
//           yields a registered {taken, hit, target, ghr} one clk later.
//           The execute stage trains the tables through the resolve port.
// Ports   : clk, rst (async, active-low)
//           ready                      high once the post-reset clear is done
//           pred_valid, pred_pc        lookup request
//           pred_out_valid, pred_taken, pred_hit, pred_target, pred_ghr
//                                      registered lookup result
//           upd_valid, upd_pc, upd_ghr, upd_is_branch, upd_taken,
//           upd_target, upd_mispredict resolve / recovery strobe
module gshare_btb_predictor
  import gshare_pkg::*;
#(
  parameter int         GHR_BITS     = 7,
  parameter int         PHT_IDX_BITS = 7,
  parameter int         BTB_IDX_BITS = 7,
  parameter logic [1:0] PHT_INIT     = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic                pred_valid,
  input  logic [31:0]         pred_pc,
  output logic                pred_out_valid,
  output logic                pred_taken,
  output logic                pred_hit,
  output logic [31:0]         pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_is_branch,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic                upd_mispredict
);

  localparam int TAG_BITS   = 30 - BTB_IDX_BITS;
  localparam int DEPTH_BITS = (PHT_IDX_BITS > BTB_IDX_BITS) ? PHT_IDX_BITS : BTB_IDX_BITS;
  localparam int PHT_DEPTH  = 1 << PHT_IDX_BITS;
  localparam int BTB_DEPTH  = 1 << BTB_IDX_BITS;

  // ---------------- INIT / RUN FSM ----------------
  state_t                state_q, state_d;
  logic [DEPTH_BITS-1:0] cnt_q, cnt_d;
  logic                  clr_active;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_active = 1'b0;
    case (state_q)
      INIT: begin
        clr_active = 1'b1;
        cnt_d      = cnt_q + DEPTH_BITS'(1);
        if (cnt_q == '1) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign ready = (state_q == RUN);

  // The sweep covers the larger table; the smaller one skips high indices.
  logic pht_clr_en, btb_clr_en;
  assign pht_clr_en = clr_active && (int'(cnt_q) < PHT_DEPTH);
  assign btb_clr_en = clr_active && (int'(cnt_q) < BTB_DEPTH);

  // ---------------- request qualification ----------------
  logic pred_acc, upd_acc, upd_train, recover;
  assign pred_acc  = pred_valid & ready;
  assign upd_acc   = upd_valid & ready;
  assign upd_train = upd_acc & upd_is_branch;
  assign recover   = upd_acc & upd_mispredict;

  // ---------------- index / tag formation ----------------
  logic [GHR_BITS-1:0]     spec_ghr;
  logic [PHT_IDX_BITS-1:0] pred_pht_idx, upd_pht_idx;
  logic [BTB_IDX_BITS-1:0] pred_btb_idx, upd_btb_idx;
  logic [29:0]             pred_tag, upd_tag;

  assign pred_pht_idx = pred_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(spec_ghr);
  assign upd_pht_idx  = upd_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(upd_ghr);
  assign pred_btb_idx = pred_pc[BTB_IDX_BITS+1:2];
  assign upd_btb_idx  = upd_pc[BTB_IDX_BITS+1:2];
  assign pred_tag     = 30'(pred_pc[31:32-TAG_BITS]);
  assign upd_tag      = 30'(upd_pc[31:32-TAG_BITS]);

  // ---------------- PHT ----------------
  logic [1:0] pht_rd_ctr;

  gshare_pht #(
    .IDX_BITS (PHT_IDX_BITS),
    .INIT_VAL (PHT_INIT)
  ) u_pht (
    .clk     (clk),
    .rd_idx  (pred_pht_idx),
    .rd_ctr  (pht_rd_ctr),
    .upd_en  (upd_train),
    .upd_idx (upd_pht_idx),
    .upd_up  (upd_taken),
    .clr_en  (pht_clr_en),
    .clr_idx (cnt_q[PHT_IDX_BITS-1:0])
  );

  // ---------------- BTB ----------------
  btb_entry_t btb [BTB_DEPTH];
  btb_entry_t pred_entry;

  assign pred_entry = btb[pred_btb_idx];

  // Only taken branches allocate; a not-taken resolve leaves the entry alone.
  always_ff @(posedge clk) begin
    if (btb_clr_en) begin
      btb[cnt_q[BTB_IDX_BITS-1:0]].valid <= 1'b0;
    end else if (upd_train && upd_taken) begin
      btb[upd_btb_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target};
    end
  end

  // ---------------- lookup result ----------------
  logic        lk_hit, lk_taken;
  logic [31:0] lk_target;

  assign lk_hit    = pred_entry.valid && (pred_entry.tag == pred_tag);
  assign lk_taken  = pht_rd_ctr[1] & lk_hit;
  assign lk_target = lk_taken ? pred_entry.target : pred_pc + FALLTHRU;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
      pred_hit       <= 1'b0;
      pred_target    <= '0;
      pred_ghr       <= '0;
      spec_ghr       <= '0;
    end else begin
      pred_out_valid <= pred_acc;
      if (pred_acc) begin
        pred_taken  <= lk_taken;
        pred_hit    <= lk_hit;
        pred_target <= lk_target;
        pred_ghr    <= spec_ghr;
      end
      // Recovery wins over a same-cycle speculative shift; misses never shift.
      if (recover) begin
        spec_ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken};
      end else if (pred_acc && lk_hit) begin
        spec_ghr <= {spec_ghr[GHR_BITS-2:0], lk_taken};
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{pred_pc[1:0], upd_pc[1:0], upd_ghr[GHR_BITS-1], pht_rd_ctr[0]};

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// tb/tb_gshare_btb_predictor.sv - directed self-checking bench for gshare_btb_predictor
module tb_gshare_btb_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_out_valid, pred_taken, pred_hit;
  logic [31:0] pred_target;
  logic [6:0]  pred_ghr;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [6:0]  upd_ghr = '0;
  logic        upd_is_branch = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispredict = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gshare_btb_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .ready          (ready),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_out_valid (pred_out_valid),
    .pred_taken     (pred_taken),
    .pred_hit       (pred_hit),
    .pred_target    (pred_target),
    .pred_ghr       (pred_ghr),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_ghr        (upd_ghr),
    .upd_is_branch  (upd_is_branch),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict)
  );

  // Result vector layout: {out_valid, hit, taken, ghr[6:0], target[31:0]}
  logic [41:0] res;
  assign res = {pred_out_valid, pred_hit, pred_taken, pred_ghr, pred_target};

  task automatic predict(input logic [31:0] pc);
    pred_valid = 1'b1; pred_pc = pc;
    @(posedge clk); @(negedge clk);
    pred_valid = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic [6:0] ghr, input logic br,
                        input logic tk, input logic [31:0] tgt, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_ghr = ghr; upd_is_branch = br;
    upd_taken = tk; upd_target = tgt; upd_mispredict = mis;
    @(posedge clk); @(negedge clk);
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  // Non-branch mispredict with ghr=0, taken=0 forces spec_ghr back to 0.
  task automatic clear_ghr();
    update(32'h0, 7'h00, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b0; #1;
    n_checks++;
    if ({ready, res} !== 43'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", {ready, res}, 43'h0);
    end
    @(negedge clk); rst = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      @(negedge clk);
      if (k == 127) begin
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_at_127: got %b want 0", ready); end
      end
      if (k == 128) begin
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_at_128: got %b want 1", ready); end
      end
    end
    predict(32'h100);
    n_checks++;
    if (res !== {3'b100, 7'h00, 32'h104}) begin
      n_fail++; $display("FAIL first_miss: got %h want %h", res, {3'b100, 7'h00, 32'h104});
    end
    @(negedge clk);
    n_checks++;
    if (pred_out_valid !== 1'b0) begin n_fail++; $display("FAIL out_valid_pulse: got %b want 0", pred_out_valid); end
  endtask

  task automatic test_btb_alloc();
    update(32'h100, 7'h00, 1'b1, 1'b1, 32'h2000, 1'b0);
    update(32'h100, 7'h00, 1'b1, 1'b1, 32'h2000, 1'b0);
    predict(32'h100);
    n_checks++;
    if (res !== {3'b111, 7'h00, 32'h2000}) begin
      n_fail++; $display("FAIL alloc_hit_taken: got %h want %h", res, {3'b111, 7'h00, 32'h2000});
    end
  endtask

  task automatic test_saturation();
    clear_ghr();
    repeat (4) update(32'h3C, 7'h00, 1'b1, 1'b1, 32'h500, 1'b0);
    predict(32'h3C);
    n_checks++;
    if (res !== {3'b111, 7'h00, 32'h500}) begin
      n_fail++; $display("FAIL sat_high: got %h want %h", res, {3'b111, 7'h00, 32'h500});
    end
    clear_ghr();
    repeat (4) update(32'h3C, 7'h00, 1'b1, 1'b0, 32'h500, 1'b0);
    predict(32'h3C);
    n_checks++;
    if (res !== {3'b110, 7'h00, 32'h40}) begin
      n_fail++; $display("FAIL sat_low: got %h want %h", res, {3'b110, 7'h00, 32'h40});
    end
    clear_ghr();
    update(32'h3C, 7'h00, 1'b1, 1'b1, 32'h500, 1'b0);
    predict(32'h3C);
    n_checks++;
    if (res !== {3'b110, 7'h00, 32'h40}) begin
      n_fail++; $display("FAIL ctr_0_to_1: got %h want %h", res, {3'b110, 7'h00, 32'h40});
    end
    clear_ghr();
    update(32'h3C, 7'h00, 1'b1, 1'b1, 32'h500, 1'b0);
    predict(32'h3C);
    n_checks++;
    if (res !== {3'b111, 7'h00, 32'h500}) begin
      n_fail++; $display("FAIL ctr_1_to_2: got %h want %h", res, {3'b111, 7'h00, 32'h500});
    end
  endtask

  task automatic test_recovery();
    clear_ghr();
    predict(32'h100);
    n_checks++;
    if (res !== {3'b111, 7'h00, 32'h2000}) begin
      n_fail++; $display("FAIL rec_pred1: got %h want %h", res, {3'b111, 7'h00, 32'h2000});
    end
    predict(32'h100);
    n_checks++;
    if (res !== {3'b110, 7'h01, 32'h104}) begin
      n_fail++; $display("FAIL rec_pred2_shift: got %h want %h", res, {3'b110, 7'h01, 32'h104});
    end
    update(32'h0, 7'h05, 1'b0, 1'b0, 32'h0, 1'b1);
    predict(32'h3C);
    n_checks++;
    if (res !== {3'b110, 7'h0A, 32'h40}) begin
      n_fail++; $display("FAIL rec_ghr: got %h want %h", res, {3'b110, 7'h0A, 32'h40});
    end
  endtask

  task automatic test_same_cycle();
    pred_valid = 1'b1; pred_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h0; upd_ghr = 7'h33; upd_is_branch = 1'b0;
    upd_taken = 1'b1; upd_target = 32'h0; upd_mispredict = 1'b1;
    @(posedge clk); @(negedge clk);
    pred_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    n_checks++;
    if (res !== {3'b110, 7'h14, 32'h104}) begin
      n_fail++; $display("FAIL same_cycle_old_ghr: got %h want %h", res, {3'b110, 7'h14, 32'h104});
    end
    predict(32'h3C);
    n_checks++;
    if (res !== {3'b110, 7'h67, 32'h40}) begin
      n_fail++; $display("FAIL same_cycle_recovery: got %h want %h", res, {3'b110, 7'h67, 32'h40});
    end
  endtask

  task automatic test_back_to_back();
    clear_ghr();
    predict(32'hFFFF_FFFC);
    n_checks++;
    if (res !== {3'b100, 7'h00, 32'h0}) begin
      n_fail++; $display("FAIL pc_wrap: got %h want %h", res, {3'b100, 7'h00, 32'h0});
    end
    pred_valid = 1'b1; pred_pc = 32'h400;
    upd_valid = 1'b1; upd_pc = 32'h400; upd_ghr = 7'h00; upd_is_branch = 1'b1;
    upd_taken = 1'b1; upd_target = 32'h800; upd_mispredict = 1'b0;
    @(posedge clk); @(negedge clk);
    upd_valid = 1'b0;
    n_checks++;
    if (res !== {3'b100, 7'h00, 32'h404}) begin
      n_fail++; $display("FAIL b2b_old_entry: got %h want %h", res, {3'b100, 7'h00, 32'h404});
    end
    @(posedge clk); @(negedge clk);
    pred_valid = 1'b0;
    n_checks++;
    if (res !== {3'b111, 7'h00, 32'h800}) begin
      n_fail++; $display("FAIL b2b_new_entry: got %h want %h", res, {3'b111, 7'h00, 32'h800});
    end
  endtask

  task automatic test_mid_reset();
    clear_ghr();
    predict(32'h100);
    n_checks++;
    if (res !== {3'b111, 7'h00, 32'h2000}) begin
      n_fail++; $display("FAIL pre_reset_hit: got %h want %h", res, {3'b111, 7'h00, 32'h2000});
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({ready, res} !== 43'h0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h want %h", {ready, res}, 43'h0);
    end
    @(negedge clk); rst = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      @(negedge clk);
      if (k == 127) begin
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL re_ready_at_127: got %b want 0", ready); end
      end
      if (k == 128) begin
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL re_ready_at_128: got %b want 1", ready); end
      end
    end
    predict(32'h100);
    n_checks++;
    if (res !== {3'b100, 7'h00, 32'h104}) begin
      n_fail++; $display("FAIL btb_recleared: got %h want %h", res, {3'b100, 7'h00, 32'h104});
    end
    update(32'h100, 7'h00, 1'b1, 1'b1, 32'h2000, 1'b0);
    update(32'h100, 7'h00, 1'b1, 1'b0, 32'h2000, 1'b0);
    predict(32'h100);
    n_checks++;
    if (res !== {3'b110, 7'h00, 32'h104}) begin
      n_fail++; $display("FAIL pht_recleared: got %h want %h", res, {3'b110, 7'h00, 32'h104});
    end
  endtask

  initial begin
    test_reset();
    test_btb_alloc();
    test_saturation();
    test_recovery();
    test_same_cycle();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
